// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared constants, state encoding and funct3 legality for the load/store unit
package dmem_lsu_pkg;

  localparam int LSU_ADDR_W = 12;
  localparam int LSU_XLEN   = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - core request/response and data RAM bus seen by the load/store unit
interface dmem_lsu_if #(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_we;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// rtl/dmem_lsu_lane.sv - byte/half lane extraction with extension, and sub-word merge into a RAM word
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = '0;
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        load_o = {{24{byte_sel[7]}}, byte_sel};
        merged_o[{offset_i, 3'b000} +: 8] = sdata_i[7:0];
      end
      F3_H: begin
        load_o = {{16{half_sel[15]}}, half_sel};
        if (offset_i[1]) merged_o[31:16] = sdata_i[15:0];
        else             merged_o[15:0]  = sdata_i[15:0];
      end
      F3_W: begin
        load_o   = word_i;
        merged_o = sdata_i;
      end
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit in front of a word-wide RAM without byte enables
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int XLEN   = LSU_XLEN
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);
  lsu_state_e        state_q;
  logic              ready_q;
  logic              err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;
  logic            out_of_range;
  logic            misaligned;
  logic            req_err;

  always_comb begin
    out_of_range = |bus.req_addr[XLEN-1:ADDR_W+2];
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_err      = f3_illegal(bus.req_store, bus.req_funct3) || out_of_range || misaligned;
  end

  dmem_lsu_lane u_lane (
    .word_i   (bus.mem_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .sdata_i  (wdata_q),
    .load_o   (load_val),
    .merged_o (merged)
  );

  // wdata_q doubles as the store word: raw data for SW, merged word after RMW_RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            err_q   <= req_err;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            if (req_err)                   state_q <= S_RESP;
            else if (!bus.req_store)       state_q <= S_LOAD;
            else if (bus.req_funct3 == F3_W) state_q <= S_WRITE;
            else                           state_q <= S_RMW_RD;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          rdata_q <= load_val;
          state_q <= S_RESP;
        end
        S_RMW_RD: begin
          wdata_q <= merged;
          state_q <= S_WRITE;
        end
        S_WRITE: state_q <= S_RESP;
        S_RESP: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_addr  = (state_q == S_IDLE) ? '0 : addr_q[ADDR_W+1:2];
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_wdata = (state_q == S_WRITE) ? wdata_q : '0;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu against a byte-level reference model
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(12), .XLEN(32)) bus ();
  dmem_lsu #(.ADDR_W(12), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          we_count = 0;
  int          total = 0;
  int          bad = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      we_count <= we_count + 1;
    end
  end

  // Reference: RAM seen as bytes; sizes and legality from the RV32I load/store rules
  function automatic void ref_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int size, idx, sh;
    bit uns, legal;
    longint unsigned mask, v;
    size = 4; uns = 0; legal = 1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; legal = !st; end
      3'd5: begin size = 2; uns = 1; legal = !st; end
      default: legal = 0;
    endcase
    er = !legal || ((a >> 14) != 0) || ((a % size) != 0);
    rd = '0;
    if (er) return;
    idx  = int'(a / 4);
    sh   = int'(a % 4) * 8;
    mask = (64'd1 << (8 * size)) - 1;
    if (!st) begin
      v = (longint'(ref_mem[idx]) >> sh) & mask;
      if (!uns && size < 4 && v[8*size-1]) v = v | ~mask;
      rd = v[31:0];
    end else begin
      v = (longint'(ref_mem[idx]) & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
      ref_mem[idx] = v[31:0];
    end
  endfunction

  function automatic int exp_lat(input bit st, input logic [2:0] f3, input bit er);
    if (er) return 1;
    if (!st || f3 == F3_W) return 2;
    return 3;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = idx[11:0]; pl_val = v;
    @(posedge clk);
    #1 pl_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Issues one request and reports latency in negedges after the accepting edge
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int lat, output int nwe, output int we_c);
    int w0;
    lat = -1; we_c = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    w0 = we_count;
    @(posedge clk);
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_we === 1'b1 && we_c < 0) we_c = c;
      if (bus.rsp_valid === 1'b1) begin lat = c; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
    nwe = we_count - w0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 6;
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp: got %b%b want 00", bus.rsp_valid, bus.rsp_err); end
    if (bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
    if (bus.mem_addr !== 12'd0) begin bad++; $display("FAIL rst_maddr: got %h want 0", bus.mem_addr); end
    if (bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mwdata: got %h want 0", bus.mem_wdata); end
    if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL post_rst_strobes: got %b%b want 00", bus.rsp_valid, bus.mem_we); end
    if (bus.mem_addr !== 12'd0 || bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL post_rst_bus: got %h/%h want 0/0", bus.mem_addr, bus.rsp_rdata); end
  endtask

  task automatic test_loads();
    logic [2:0] f3s [5];
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, nwe, we_c;
    f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;
    preload(5, 32'h8899AABB);
    for (int f = 0; f < 5; f++) begin
      for (int o = 0; o < 4; o++) begin
        ref_access(1'b0, f3s[f], 32'h14 + o, 32'd0, erd, eer);
        do_req(1'b0, f3s[f], 32'h14 + o, 32'd0, rd, er, lat, nwe, we_c);
        total += 3;
        if (rd !== erd || er !== eer) begin bad++; $display("FAIL load_rsp f3=%0d addr=%h: got %h/%b want %h/%b", f3s[f], 32'h14 + o, rd, er, erd, eer); end
        if (lat !== exp_lat(1'b0, f3s[f], eer)) begin bad++; $display("FAIL load_lat f3=%0d addr=%h: got %0d want %0d", f3s[f], 32'h14 + o, lat, exp_lat(1'b0, f3s[f], eer)); end
        if (nwe !== 0) begin bad++; $display("FAIL load_we f3=%0d: got %0d writes want 0", f3s[f], nwe); end
      end
    end
  endtask

  task automatic test_sub_store();
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, nwe, we_c;
    preload(5, 32'h8899AABB);
    ref_access(1'b1, F3_H, 32'h16, 32'h1234CDEF, erd, eer);
    do_req(1'b1, F3_H, 32'h16, 32'h1234CDEF, rd, er, lat, nwe, we_c);
    total += 4;
    if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sh_rsp: got %h/%b want 0/0", rd, er); end
    if (lat !== 3) begin bad++; $display("FAIL sh_lat: got %0d want 3", lat); end
    if (nwe !== 1 || we_c !== 2) begin bad++; $display("FAIL sh_we: got %0d writes at %0d want 1 at 2", nwe, we_c); end
    if (mem[5] !== ref_mem[5]) begin bad++; $display("FAIL sh_word: got %h want %h", mem[5], ref_mem[5]); end
    ref_access(1'b0, F3_W, 32'h14, 32'd0, erd, eer);
    do_req(1'b0, F3_W, 32'h14, 32'd0, rd, er, lat, nwe, we_c);
    total++;
    if (rd !== erd || er !== eer) begin bad++; $display("FAIL sh_readback: got %h/%b want %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_bounds();
    logic        st  [6];
    logic [31:0] ad  [6];
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, nwe, we_c;
    st[0] = 1; ad[0] = 32'h3FFC;
    st[1] = 0; ad[1] = 32'h3FFC;
    st[2] = 1; ad[2] = 32'h0FFC;
    st[3] = 0; ad[3] = 32'h1000;
    st[4] = 0; ad[4] = 32'h4000;
    st[5] = 1; ad[5] = 32'hFFFF_FFFC;
    preload(1024, 32'h0BAD_F00D);
    for (int i = 0; i < 6; i++) begin
      ref_access(st[i], F3_W, ad[i], 32'hDEADBEEF ^ i, erd, eer);
      do_req(st[i], F3_W, ad[i], 32'hDEADBEEF ^ i, rd, er, lat, nwe, we_c);
      total += 3;
      if (rd !== erd || er !== eer) begin bad++; $display("FAIL bound_rsp addr=%h: got %h/%b want %h/%b", ad[i], rd, er, erd, eer); end
      if (lat !== exp_lat(st[i], F3_W, eer)) begin bad++; $display("FAIL bound_lat addr=%h: got %0d want %0d", ad[i], lat, exp_lat(st[i], F3_W, eer)); end
      if (nwe !== ((st[i] && !eer) ? 1 : 0)) begin bad++; $display("FAIL bound_we addr=%h: got %0d writes", ad[i], nwe); end
    end
    total++;
    if (mem[4095] !== ref_mem[4095]) begin bad++; $display("FAIL bound_top_word: got %h want %h", mem[4095], ref_mem[4095]); end
  endtask

  task automatic test_errors();
    logic        st [7];
    logic [2:0]  f3 [7];
    logic [31:0] ad [7];
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, nwe, we_c;
    st[0] = 0; f3[0] = F3_H;   ad[0] = 32'h21;
    st[1] = 1; f3[1] = F3_W;   ad[1] = 32'h22;
    st[2] = 0; f3[2] = 3'b011; ad[2] = 32'h20;
    st[3] = 1; f3[3] = F3_BU;  ad[3] = 32'h20;
    st[4] = 1; f3[4] = F3_H;   ad[4] = 32'h23;
    st[5] = 0; f3[5] = 3'b110; ad[5] = 32'h20;
    st[6] = 1; f3[6] = 3'b111; ad[6] = 32'h20;
    preload(8, 32'h5566_7788);
    for (int i = 0; i < 7; i++) begin
      ref_access(st[i], f3[i], ad[i], 32'hFFFF_FFFF, erd, eer);
      do_req(st[i], f3[i], ad[i], 32'hFFFF_FFFF, rd, er, lat, nwe, we_c);
      total += 3;
      if (er !== eer || rd !== erd) begin bad++; $display("FAIL err_rsp case=%0d: got %h/%b want %h/%b", i, rd, er, erd, eer); end
      if (lat !== 1) begin bad++; $display("FAIL err_lat case=%0d: got %0d want 1", i, lat); end
      if (nwe !== 0) begin bad++; $display("FAIL err_we case=%0d: got %0d writes want 0", i, nwe); end
    end
    ref_access(1'b0, F3_W, 32'h20, 32'd0, erd, eer);
    do_req(1'b0, F3_W, 32'h20, 32'd0, rd, er, lat, nwe, we_c);
    total++;
    if (rd !== erd || er !== eer) begin bad++; $display("FAIL err_mem_kept: got %h/%b want %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, nwe, we_c, w0, seen;
    preload(40, 32'hA5A5_5A5A);
    @(negedge clk);
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'hA1; bus.req_wdata = 32'h0000_00C3;
    w0 = we_count;
    @(posedge clk);
    #2 rst = 1'b1;
    bus.req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0) seen++;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0) seen++;
    end
    total += 3;
    if (seen !== 0) begin bad++; $display("FAIL rstmid_strobes: got %0d active cycles want 0", seen); end
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
    if (we_count !== w0) begin bad++; $display("FAIL rstmid_writes: got %0d want 0", we_count - w0); end
    ref_access(1'b0, F3_W, 32'hA0, 32'd0, erd, eer);
    do_req(1'b0, F3_W, 32'hA0, 32'd0, rd, er, lat, nwe, we_c);
    total++;
    if (rd !== erd || er !== eer) begin bad++; $display("FAIL rstmid_word: got %h/%b want %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_back_to_back();
    logic        st  [4];
    logic [2:0]  f3  [4];
    logic [31:0] ad  [4];
    logic [31:0] wd  [4];
    logic [31:0] erd [4];
    bit          eer [4];
    int          acc_c [4];
    int k, r, hits, cyc;
    bit pend;
    preload(48, $urandom);
    preload(49, $urandom);
    st[0] = 0; f3[0] = F3_W;  ad[0] = 32'd192;
    st[1] = 1; f3[1] = F3_B;  ad[1] = 32'd192 + $urandom_range(0, 3);
    st[2] = 0; f3[2] = F3_HU; ad[2] = 32'd196 + 2 * $urandom_range(0, 1);
    st[3] = 1; f3[3] = F3_W;  ad[3] = 32'd196;
    for (int j = 0; j < 4; j++) begin
      wd[j] = $urandom;
      ref_access(st[j], f3[j], ad[j], wd[j], erd[j], eer[j]);
      acc_c[j] = -100;
    end
    k = 0; r = 0; hits = 0; pend = 0; cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st[0]; bus.req_funct3 = f3[0];
    bus.req_addr = ad[0]; bus.req_wdata = wd[0];
    while (cyc < 80 && r < 4) begin
      if (pend) begin
        pend = 0; k++;
        if (k < 4) begin
          bus.req_store = st[k]; bus.req_funct3 = f3[k]; bus.req_addr = ad[k]; bus.req_wdata = wd[k];
        end else bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid === 1'b1) begin
        total++;
        if (bus.rsp_rdata !== erd[r] || bus.rsp_err !== eer[r]) begin
          bad++; $display("FAIL b2b_rsp n=%0d: got %h/%b want %h/%b", r, bus.rsp_rdata, bus.rsp_err, erd[r], eer[r]);
        end
        r++;
      end
      if (bus.req_ready === 1'b1 && k < 4) begin hits++; pend = 1; acc_c[k] = cyc; end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    total += 2;
    if (r !== 4) begin bad++; $display("FAIL b2b_count: got %0d responses want 4", r); end
    if (hits !== 4) begin bad++; $display("FAIL b2b_ready: got %0d ready cycles want 4", hits); end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (acc_c[j+1] - acc_c[j] !== exp_lat(st[j], f3[j], eer[j]) + 1) begin
        bad++; $display("FAIL b2b_gap n=%0d: got %0d want %0d", j, acc_c[j+1] - acc_c[j], exp_lat(st[j], f3[j], eer[j]) + 1);
      end
    end
    total++;
    if (mem[48] !== ref_mem[48] || mem[49] !== ref_mem[49]) begin
      bad++; $display("FAIL b2b_mem: got %h %h want %h %h", mem[48], mem[49], ref_mem[48], ref_mem[49]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd;
    logic [2:0]  f3;
    bit st, er, eer;
    int lat, nwe, we_c, sel, idx;
    for (int i = 0; i < 16; i++) begin
      preload(i, $urandom);
      preload(4080 + i, $urandom);
    end
    for (int n = 0; n < 150; n++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      idx = (sel < 5) ? $urandom_range(0, 15) : $urandom_range(4080, 4095);
      a   = (sel == 9) ? ($urandom | 32'h0001_0000) : 32'(idx * 4 + $urandom_range(0, 3));
      ref_access(st, f3, a, wd, erd, eer);
      do_req(st, f3, a, wd, rd, er, lat, nwe, we_c);
      total += 3;
      if (rd !== erd || er !== eer) begin bad++; $display("FAIL rand_rsp st=%0d f3=%0d addr=%h: got %h/%b want %h/%b", st, f3, a, rd, er, erd, eer); end
      if (lat !== exp_lat(st, f3, eer)) begin bad++; $display("FAIL rand_lat st=%0d f3=%0d addr=%h: got %0d want %0d", st, f3, a, lat, exp_lat(st, f3, eer)); end
      if (nwe !== ((st && !eer) ? 1 : 0)) begin bad++; $display("FAIL rand_we st=%0d f3=%0d addr=%h: got %0d writes", st, f3, a, nwe); end
    end
    for (int i = 0; i < 16; i++) begin
      total += 2;
      if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rand_mem idx=%0d: got %h want %h", i, mem[i], ref_mem[i]); end
      if (mem[4080+i] !== ref_mem[4080+i]) begin bad++; $display("FAIL rand_mem idx=%0d: got %h want %h", 4080 + i, mem[4080+i], ref_mem[4080+i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_sub_store();
    test_bounds();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
